// File: rtl/orion_rr_merge_ctrl.sv
// orion_rr_merge_ctrl
// Clocked round-robin merge of NUM_IN two-phase bundled-data input channels
// onto one two-phase bundled-data output channel. Request toggles and the
// downstream acknowledge are brought into the clock domain through
// SYNC_STAGES-deep flop synchronizers. One input is granted at a time. Its
// data is registered onto out_data and out_req toggles once. The input is
// acknowledged only after the downstream acknowledge has come back.
//
// Build option: define ORION_RR_MERGE_FIXED_PRIO_EN to replace round-robin
// selection with fixed priority (lowest pending index wins). The default
// build, with the macro undefined, is round-robin.
//
// Handshake: all channels are two-phase. A channel holds a token while its
// req phase differs from its ack phase. The producer keeps the data stable
// from its req toggle until the matching ack toggle. The consumer samples
// the data while the token is held and retires the token by toggling ack.
// Only one output token is outstanding at any time (busy=1), and the next
// grant comes at least one IDLE cycle after the previous in_ack toggle.
//
// state_dbg exposes the FSM state: 0 = IDLE, 1 = WAIT.

module orion_rr_merge_ctrl #(
    parameter int NUM_IN      = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_IN-1:0]          in_req,
    output logic [NUM_IN-1:0]          in_ack,
    input  logic [NUM_IN*WIDTH-1:0]    in_data,
    output logic                       out_req,
    input  logic                       out_ack,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_IN)-1:0]  grant_id,
    output logic                       busy,
    output logic                       state_dbg
);

    localparam int IDW = $clog2(NUM_IN);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Synchronizer chains; the last stage of each chain is the value the FSM uses.
    logic [NUM_IN-1:0]      req_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [NUM_IN-1:0]      sreq;
    logic                   sack;

    // Registered state and outputs.
    state_t                 state_q,    state_d;
    logic [NUM_IN-1:0]      in_ack_q,   in_ack_d;
    logic                   out_req_q,  out_req_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;
    logic [IDW-1:0]         grant_q,    grant_d;
    logic                   busy_q,     busy_d;
`ifdef ORION_RR_MERGE_FIXED_PRIO_EN
`else
    logic [IDW-1:0]         last_q,     last_d;
`endif

    // Arbitration.
    logic [NUM_IN-1:0]      pending;
    logic                   win_found;
    logic [IDW-1:0]         win_idx;
    int                     cand;

    // Shift in_req and out_ack through their synchronizer chains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                req_sync[s] <= '0;
            end
            ack_sync <= '0;
        end else begin
            req_sync[0] <= in_req;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                req_sync[s] <= req_sync[s-1];
            end
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
        end
    end

    assign sreq = req_sync[SYNC_STAGES-1];
    assign sack = ack_sync[SYNC_STAGES-1];

    // A token is pending while the synchronized request phase differs from
    // the acknowledge phase already returned. The input that was just
    // acknowledged compares equal at once, so it cannot raise a false token.
    assign pending = sreq ^ in_ack_q;

    // Pick the winner. Round-robin searches from last_grant+1 upward,
    // wrapping. Fixed priority searches from index 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_IN; k++) begin
`ifdef ORION_RR_MERGE_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(last_q) + 1 + k) % NUM_IN;
`endif
            if (!win_found && pending[cand]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    // Next-state logic and output updates for the IDLE/WAIT controller.
    always_comb begin
        state_d    = state_q;
        in_ack_d   = in_ack_q;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
`ifdef ORION_RR_MERGE_FIXED_PRIO_EN
`else
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    out_data_d = in_data[int'(win_idx)*WIDTH +: WIDTH];
                    out_req_d  = ~out_req_q;
                    grant_d    = win_idx;
                    busy_d     = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // Downstream has acknowledged once its phase matches out_req.
                if (sack == out_req_q) begin
                    in_ack_d[grant_q] = ~in_ack_q[grant_q];
`ifdef ORION_RR_MERGE_FIXED_PRIO_EN
`else
                    last_d            = grant_q;
`endif
                    busy_d            = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any outstanding transaction.
    // last_grant resets to NUM_IN-1, which gives input 0 first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            in_ack_q   <= '0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
`ifdef ORION_RR_MERGE_FIXED_PRIO_EN
`else
            last_q     <= IDW'(NUM_IN - 1);
`endif
        end else begin
            state_q    <= state_d;
            in_ack_q   <= in_ack_d;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
`ifdef ORION_RR_MERGE_FIXED_PRIO_EN
`else
            last_q     <= last_d;
`endif
        end
    end

    assign in_ack    = in_ack_q;
    assign out_req   = out_req_q;
    assign out_data  = out_data_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_orion_rr_merge_ctrl.sv
// tb_orion_rr_merge_ctrl
// Scoreboard bench for orion_rr_merge_ctrl. A transaction-level reference
// model runs on every rising edge. It tracks the outstanding token of each
// input, the edge on which that token becomes visible after synchronization,
// the arbitration pointer and the downstream acknowledge. From these it
// pushes the expected per-cycle response into exp_q. A monitor on the
// falling edge pops each expectation and compares it with the DUT outputs.

module tb_orion_rr_merge_ctrl;

    localparam int NUM_IN = 4;
    localparam int W      = 8;
    localparam int SYNC   = 2;
    localparam int IDW    = $clog2(NUM_IN);

    typedef struct packed {
        logic           grant;
        logic           ack;
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           busy;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic [NUM_IN-1:0]   in_req;
    logic [NUM_IN-1:0]   in_ack;
    logic [NUM_IN*W-1:0] in_data;
    logic                out_req;
    logic                out_ack;
    logic [W-1:0]        out_data;
    logic [IDW-1:0]      grant_id;
    logic                busy;
    logic                state_dbg;

    orion_rr_merge_ctrl #(.NUM_IN(NUM_IN), .WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .in_data   (in_data),
        .out_req   (out_req),
        .out_ack   (out_ack),
        .out_data  (out_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- shared bench state ----------------
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    bit         model_en = 1'b0;
    exp_t       exp_q[$];
    int         grant_log[$];

    // Reference model state.
    logic       tok_valid [NUM_IN];
    logic [W-1:0] tok_data [NUM_IN];
    int         tok_edge  [NUM_IN];
    bit         m_busy;
    int         m_id;
    int         m_last;

    // Downstream responder state.
    int         ack_delay = 0;
    bit         ack_sched;
    int         ack_cnt;
    bit         ack_issued;
    int         ack_edge;

    // Previous outputs seen by the monitor.
    logic              prev_out_req;
    logic [NUM_IN-1:0] prev_in_ack;
    logic [W-1:0]      prev_out_data;
    logic [IDW-1:0]    prev_grant_id;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_IN; i++) begin
            tok_valid[i] = 1'b0;
            tok_data[i]  = '0;
            tok_edge[i]  = 0;
        end
        m_busy     = 1'b0;
        m_id       = 0;
        m_last     = NUM_IN - 1;
        ack_sched  = 1'b0;
        ack_cnt    = 0;
        ack_issued = 1'b0;
        ack_edge   = 0;
        exp_q.delete();
    endtask

    // Called in the middle of the clock-high phase. The reset takes effect
    // with no clock edge in between, so outputs are checked right after.
    task automatic do_reset();
        model_en = 1'b0;
        reset_n  = 1'b0;
        in_req   = '0;
        out_ack  = 1'b0;
        in_data  = '0;
        #1;
        check("rst_out_req",  32'(out_req),  32'd0);
        check("rst_in_ack",   32'(in_ack),   32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        reset_n  = 1'b1;
        model_en = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // Issue a new token on input i; call at a falling edge only when no
    // token is outstanding on that input.
    task automatic issue(input int i, input logic [W-1:0] d);
        in_data[i*W +: W] = d;
        in_req[i]         = ~in_req[i];
        tok_data[i]       = d;
        tok_edge[i]       = cyc + 1;
        tok_valid[i]      = 1'b1;
    endtask

    function automatic bit all_quiet();
        bit q;
        q = !m_busy && (exp_q.size() == 0);
        for (int i = 0; i < NUM_IN; i++) begin
            if (tok_valid[i]) q = 1'b0;
        end
        return q;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!all_quiet() && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!all_quiet()) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!(busy === 1'b1 && out_req === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_busy", 32'(busy === 1'b1 && out_req === 1'b1), 32'd1);
    endtask

    task automatic check_log(input string name, input int exp[]);
        check({name, "_len"}, 32'(grant_log.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < grant_log.size(); k++) begin
            check(name, 32'(grant_log[k]), 32'(exp[k]));
        end
    endtask

    // ---------------- reference model ----------------
    // Each rising edge: in WAIT, the acknowledge completes SYNC edges after
    // out_ack toggled. In IDLE, a token is eligible SYNC edges after its
    // in_req toggle, and the winner is the first eligible input after the
    // last granted one (or the lowest index under fixed priority).
    initial begin : model_proc
        int   w;
        int   j;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (model_en) begin
                e = '0;
                if (m_busy) begin
                    if (ack_issued && cyc >= ack_edge + SYNC) begin
                        e.ack             = 1'b1;
                        e.id              = IDW'(m_id);
                        ack_issued        = 1'b0;
                        m_busy            = 1'b0;
                        m_last            = m_id;
                        tok_valid[m_id]   = 1'b0;
                    end
                end else begin
                    w = -1;
                    for (int k = 0; k < NUM_IN; k++) begin
`ifdef ORION_RR_MERGE_FIXED_PRIO_EN
                        j = k;
`else
                        j = (m_last + 1 + k) % NUM_IN;
`endif
                        if (w < 0 && tok_valid[j] && cyc >= tok_edge[j] + SYNC) w = j;
                    end
                    if (w >= 0) begin
                        e.grant = 1'b1;
                        e.id    = IDW'(w);
                        e.data  = tok_data[w];
                        m_busy  = 1'b1;
                        m_id    = w;
                    end
                end
                e.busy = m_busy;
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- downstream responder ----------------
    initial begin : responder_proc
        forever begin
            @(negedge clk);
            if (model_en) begin
                if (out_req !== out_ack && !ack_sched) begin
                    ack_sched = 1'b1;
                    ack_cnt   = ack_delay;
                end
                if (ack_sched) begin
                    if (ack_cnt == 0) begin
                        out_ack    = ~out_ack;
                        ack_sched  = 1'b0;
                        ack_edge   = cyc + 1;
                        ack_issued = 1'b1;
                    end else begin
                        ack_cnt--;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor_proc
        exp_t              e;
        logic [NUM_IN-1:0] exp_vec;
        forever begin
            @(negedge clk);
            if (model_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant_event", 32'(out_req ^ prev_out_req), 32'(e.grant));
                exp_vec = '0;
                if (e.ack) exp_vec[e.id] = 1'b1;
                check("in_ack_toggle", 32'(in_ack ^ prev_in_ack), 32'(exp_vec));
                check("busy", 32'(busy), 32'(e.busy));
                check("fsm_state", 32'(state_dbg), 32'(e.busy));
                if (e.grant) begin
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("out_data", 32'(out_data), 32'(e.data));
                end else begin
                    check("grant_id_hold", 32'(grant_id), 32'(prev_grant_id));
                    check("out_data_hold", 32'(out_data), 32'(prev_out_data));
                end
                if (out_req !== prev_out_req) grant_log.push_back(int'(grant_id));
            end
            prev_out_req  = out_req;
            prev_in_ack   = in_ack;
            prev_out_data = out_data;
            prev_grant_id = grant_id;
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog_proc
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main_proc
        reset_n = 1'b1;
        in_req  = '0;
        out_ack = 1'b0;
        in_data = '0;
        model_clear();
        @(posedge clk);
        #3;
        do_reset();

        // Single token on input 2 with data 0xA5; downstream echoes at once.
        ack_delay = 0;
        @(negedge clk);
        issue(2, 8'hA5);
        wait_idle(60);

        // All four request together, two rounds; out_ack echoes after 2 cycles.
        @(posedge clk);
        #3;
        do_reset();
        ack_delay = 2;
        grant_log.delete();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_IN; i++) issue(i, W'($urandom_range(0, 255)));
            wait_idle(200);
        end
`ifdef ORION_RR_MERGE_FIXED_PRIO_EN
        check_log("fair_order", '{0, 1, 2, 3, 0, 1, 2, 3});
`else
        check_log("fair_order", '{0, 1, 2, 3, 0, 1, 2, 3});
`endif

        // Input 1 granted, input 0 arrives during WAIT.
        ack_delay = 6;
        grant_log.delete();
        @(negedge clk);
        issue(1, 8'h11);
        wait_busy(20);
        @(negedge clk);
        issue(0, 8'h00 + 8'h5A);
        wait_idle(100);
        check_log("wait_arrival", '{1, 0});

        // Reset in the middle of a transaction.
        ack_delay = 50;
        @(negedge clk);
        issue(3, 8'h3C);
        wait_busy(20);
        @(posedge clk);
        #3;
        do_reset();
        ack_delay = 1;
        grant_log.delete();
        @(negedge clk);
        issue(2, 8'h22);
        issue(1, 8'h21);
        issue(0, 8'h20);
        wait_idle(100);
        check("post_reset_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

        // Stalled downstream for 100 cycles.
        ack_delay = 100;
        @(negedge clk);
        issue(2, 8'hC3);
        wait_idle(200);

        // Inputs 0 and 3 request continuously.
        @(posedge clk);
        #3;
        do_reset();
        ack_delay = 1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (!tok_valid[0]) issue(0, W'($urandom_range(0, 255)));
            if (!tok_valid[3]) issue(3, W'($urandom_range(0, 255)));
        end
        wait_idle(100);

        // Randomized traffic with random downstream delay.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            ack_delay = $urandom_range(0, 5);
            for (int i = 0; i < NUM_IN; i++) begin
                if (!tok_valid[i] && $urandom_range(0, 2) == 0) issue(i, W'($urandom_range(0, 255)));
            end
        end
        wait_idle(300);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
